// File: rtl/dm_dual_responder.sv
// ============================================================================
// Module   : dm_dual_responder
// Brief    : Dual-port data memory for two issue slots (p0 older, p1 younger)
//            with write-first forwarding and a zero-clear sequence after reset.
// Revision : 1.0
// ============================================================================
`default_nettype none

module dm_dual_responder #(
    parameter int ADDR_W         = 9,
    parameter int DATA_W         = 16,
    parameter int DEPTH          = 512,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] p0_DM_maddr,
    input  logic [DATA_W-1:0] p0_DM_wdata,
    input  logic              p0_DM_write_mem,
    output logic [DATA_W-1:0] p0_DM_rdata,
    input  logic [ADDR_W-1:0] p1_DM_maddr,
    input  logic [DATA_W-1:0] p1_DM_wdata,
    input  logic              p1_DM_write_mem,
    output logic [DATA_W-1:0] p1_DM_rdata,
    output logic              init_busy
);

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    localparam state_t            RST_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_C   = (ADDR_W + 1)'(DEPTH);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]   rd0_q, rd0_d;
    logic [DATA_W-1:0]   rd1_q, rd1_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic clr_we, p0_we, p1_we;
    logic p0_in_range, p1_in_range;

    assign p0_in_range = ({1'b0, p0_DM_maddr} < DEPTH_C);
    assign p1_in_range = ({1'b0, p1_DM_maddr} < DEPTH_C);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clr_we  = 1'b0;
        p0_we   = 1'b0;
        p1_we   = 1'b0;
        rd0_d   = '0;
        rd1_d   = '0;
        case (state_q)
            CLEAR: begin
                clr_we = 1'b1;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LAST_ADDR) begin
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                p0_we = p0_DM_write_mem & p0_in_range;
                p1_we = p1_DM_write_mem & p1_in_range;
                // Write-first: the younger slot's store wins over the older one.
                if (p1_we && (p1_DM_maddr == p0_DM_maddr))
                    rd0_d = p1_DM_wdata;
                else if (p0_we)
                    rd0_d = p0_DM_wdata;
                else if (p0_in_range)
                    rd0_d = mem_q[p0_DM_maddr];
                if (p1_we)
                    rd1_d = p1_DM_wdata;
                else if (p0_we && (p0_DM_maddr == p1_DM_maddr))
                    rd1_d = p0_DM_wdata;
                else if (p1_in_range)
                    rd1_d = mem_q[p1_DM_maddr];
            end
            default: begin
                state_d = CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RST_STATE;
            cnt_q   <= '0;
            rd0_q   <= '0;
            rd1_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd0_q   <= rd0_d;
            rd1_q   <= rd1_d;
        end
    end

    // The array has no reset; p1 is written last so it wins a same-address conflict.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (clr_we) begin
                mem_q[cnt_q] <= '0;
            end else begin
                if (p0_we) mem_q[p0_DM_maddr] <= p0_DM_wdata;
                if (p1_we) mem_q[p1_DM_maddr] <= p1_DM_wdata;
            end
        end
    end

    assign p0_DM_rdata = rd0_q;
    assign p1_DM_rdata = rd1_q;
    assign init_busy   = (state_q == CLEAR);

endmodule

`default_nettype wire

// File: tb/tb_dm_dual_responder.sv
// ============================================================================
// Module   : tb_dm_dual_responder
// Brief    : Directed vector bench for dm_dual_responder.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_dm_dual_responder;

    logic        clk;
    logic        rst;
    logic [8:0]  a0, a1;
    logic [15:0] d0, d1;
    logic        w0, w1;
    logic [15:0] q0, q1;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    dm_dual_responder #(
        .ADDR_W(9), .DATA_W(16), .DEPTH(512), .CLEAR_ON_RESET(1)
    ) dut (
        .clk(clk), .rst(rst),
        .p0_DM_maddr(a0), .p0_DM_wdata(d0), .p0_DM_write_mem(w0), .p0_DM_rdata(q0),
        .p1_DM_maddr(a1), .p1_DM_wdata(d1), .p1_DM_write_mem(w1), .p1_DM_rdata(q1),
        .init_busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [8:0]  a0;
        logic [15:0] d0;
        logic        w0;
        logic [8:0]  a1;
        logic [15:0] d1;
        logic        w1;
        logic [15:0] e0;
        logic [15:0] e1;
    } vec_t;

    vec_t vt[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [8:0] x0, input logic [15:0] y0, input logic z0,
                         input logic [8:0] x1, input logic [15:0] y1, input logic z1);
        a0 = x0; d0 = y0; w0 = z0;
        a1 = x1; d1 = y1; w1 = z1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Counts edges until init_busy drops; optional store at edge wr_at, early exit at stop_at.
    task automatic clear_run(input int wr_at, input int stop_at, output int n);
        n = 0;
        while (busy && n < 2000) begin
            if (n == wr_at - 1) drive(9'h003, 16'hFFFF, 1'b1, 9'h1FF, 16'h0, 1'b0);
            step();
            n++;
            if (n == wr_at) begin
                drive(9'h000, 16'h0, 1'b0, 9'h1FF, 16'h0, 1'b0);
                chk("rdata0_held_in_clear", {16'h0, q0}, 32'h0);
            end
            if (n == stop_at) return;
        end
    endtask

    task automatic read_zero_checks(input string tag);
        drive(9'h000, 16'h0, 1'b0, 9'h1FF, 16'h0, 1'b0);
        step();
        chk({tag, "_p0_0x000"}, {16'h0, q0}, 32'h0);
        chk({tag, "_p1_0x1FF"}, {16'h0, q1}, 32'h0);
        drive(9'h1FF, 16'h0, 1'b0, 9'h003, 16'h0, 1'b0);
        step();
        chk({tag, "_p0_0x1FF"}, {16'h0, q0}, 32'h0);
        chk({tag, "_p1_0x003"}, {16'h0, q1}, 32'h0);
    endtask

    initial begin
        int n;
        vt[0]  = '{9'h005, 16'h1234, 1'b1, 9'h006, 16'h0000, 1'b0, 16'h1234, 16'h0000};
        vt[1]  = '{9'h006, 16'h0000, 1'b0, 9'h005, 16'h0000, 1'b0, 16'h0000, 16'h1234};
        vt[2]  = '{9'h00A, 16'hAAAA, 1'b1, 9'h00A, 16'h5555, 1'b1, 16'h5555, 16'h5555};
        vt[3]  = '{9'h00A, 16'h0000, 1'b0, 9'h005, 16'h0000, 1'b0, 16'h5555, 16'h1234};
        vt[4]  = '{9'h007, 16'h0002, 1'b1, 9'h1FF, 16'h0000, 1'b0, 16'h0002, 16'h0000};
        vt[5]  = '{9'h007, 16'h0000, 1'b0, 9'h007, 16'h0064, 1'b1, 16'h0064, 16'h0064};
        vt[6]  = '{9'h007, 16'h0000, 1'b0, 9'h007, 16'h0000, 1'b0, 16'h0064, 16'h0064};
        vt[7]  = '{9'h1FF, 16'hBEEF, 1'b1, 9'h000, 16'h0F0F, 1'b1, 16'hBEEF, 16'h0F0F};
        vt[8]  = '{9'h000, 16'h0000, 1'b0, 9'h1FF, 16'h0000, 1'b0, 16'h0F0F, 16'hBEEF};
        vt[9]  = '{9'h020, 16'h1111, 1'b1, 9'h020, 16'h0000, 1'b0, 16'h1111, 16'h1111};
        vt[10] = '{9'h021, 16'h2222, 1'b1, 9'h020, 16'h3333, 1'b1, 16'h2222, 16'h3333};
        vt[11] = '{9'h020, 16'h0000, 1'b0, 9'h021, 16'h0000, 1'b0, 16'h3333, 16'h2222};
        vt[12] = '{9'h005, 16'hDEAD, 1'b0, 9'h00A, 16'hBEEF, 1'b0, 16'h1234, 16'h5555};
        vt[13] = '{9'h00A, 16'h0000, 1'b0, 9'h005, 16'h0000, 1'b0, 16'h5555, 16'h1234};

        drive(9'h000, 16'h0, 1'b0, 9'h1FF, 16'h0, 1'b0);
        rst = 1'b0;
        #1 rst = 1'b1;
        #2;
        chk("reset_busy", {31'h0, busy}, 32'h1);
        chk("reset_rdata0", {16'h0, q0}, 32'h0);
        chk("reset_rdata1", {16'h0, q1}, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Initial clear with a store attempted at edge 10 that must be dropped.
        clear_run(10, -1, n);
        chk("clear_edges", n, 512);
        chk("busy_low_after_clear", {31'h0, busy}, 32'h0);
        read_zero_checks("clear1");

        foreach (vt[i]) begin
            drive(vt[i].a0, vt[i].d0, vt[i].w0, vt[i].a1, vt[i].d1, vt[i].w1);
            step();
            chk($sformatf("vec%0d_p0", i), {16'h0, q0}, {16'h0, vt[i].e0});
            chk($sformatf("vec%0d_p1", i), {16'h0, q1}, {16'h0, vt[i].e1});
        end

        // Reset from RUN clears rdata asynchronously and restarts the clear.
        drive(9'h000, 16'h0, 1'b0, 9'h1FF, 16'h0, 1'b0);
        rst = 1'b1;
        #1;
        chk("run_reset_busy", {31'h0, busy}, 32'h1);
        chk("run_reset_rdata0", {16'h0, q0}, 32'h0);
        chk("run_reset_rdata1", {16'h0, q1}, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;

        clear_run(-1, 200, n);
        chk("midclear_reached_200", n, 200);
        chk("midclear_busy", {31'h0, busy}, 32'h1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        clear_run(-1, -1, n);
        chk("reclear_edges", n, 512);
        chk("busy_low_after_reclear", {31'h0, busy}, 32'h0);
        read_zero_checks("clear2");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
